// File: rtl/rgb_led_arbiter.sv
// Fixed-priority arbiter with a minimum grant hold, sharing one RGB LED driver among three
// requesters. The granted colour drives three PWM channels whose duties update only at a wrap.
module rgb_led_arbiter #(
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned HOLD_COUNT = 6000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            req,
    input  logic [3*PWM_BITS-1:0] color0,
    input  logic [3*PWM_BITS-1:0] color1,
    input  logic [3*PWM_BITS-1:0] color2,
    output logic [2:0]            grant,
    output logic                  busy,
    output logic                  rgb0_pwm,
    output logic                  rgb1_pwm,
    output logic                  rgb2_pwm
);

    localparam int unsigned       HOLD_W    = (HOLD_COUNT > 1) ? $clog2(HOLD_COUNT) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_COUNT - 1);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    state_e                     state_q, state_d;
    logic [2:0]                 grant_q, grant_d;
    logic [HOLD_W-1:0]          hold_q, hold_d;
    logic [2:0]                 higher;
    logic [3*PWM_BITS-1:0]      color_q, color_d;
    logic [PWM_BITS-1:0]        pwm_cnt_q;
    logic [2:0][PWM_BITS-1:0]   duty_q, duty_d;
    logic [2:0]                 pwm_q, pwm_d;

    // Isolate the lowest set bit, i.e. the highest-priority requester.
    function automatic logic [2:0] pick_low(input logic [2:0] v);
        return v & (~v + 3'd1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        hold_d  = hold_q;
        // Requesters with a lower index than the current grant outrank it.
        higher  = req & (grant_q - 3'd1);
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d = StActive;
                    grant_d = pick_low(req);
                    hold_d  = HOLD_INIT;
                end
            end
            StActive: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - HOLD_W'(1);
                end else if (|higher) begin
                    grant_d = pick_low(higher);
                    hold_d  = HOLD_INIT;
                end else if (!(|(req & grant_q))) begin
                    if (|req) begin
                        grant_d = pick_low(req);
                        hold_d  = HOLD_INIT;
                    end else begin
                        state_d = StIdle;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
                hold_d  = '0;
            end
        endcase
    end

    always_comb begin
        grant = grant_q;
        busy  = |grant_q;
    end

    // Latch follows the requester being granted at this edge, so the grant cycle is captured.
    always_comb begin
        color_d = color_q;
        if (grant_d[0] && req[0]) begin
            color_d = color0;
        end else if (grant_d[1] && req[1]) begin
            color_d = color1;
        end else if (grant_d[2] && req[2]) begin
            color_d = color2;
        end
    end

    always_comb begin
        duty_d = duty_q;
        if (pwm_cnt_q == '1) begin
            duty_d = (state_q == StActive) ? color_q : '0;
        end
        for (int i = 0; i < 3; i++) begin
            pwm_d[i] = pwm_cnt_q < duty_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            color_q   <= '0;
            pwm_cnt_q <= '0;
            duty_q    <= '0;
            pwm_q     <= '0;
        end else begin
            color_q   <= color_d;
            pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
            duty_q    <= duty_d;
            pwm_q     <= pwm_d;
        end
    end

    assign rgb0_pwm = pwm_q[0];
    assign rgb1_pwm = pwm_q[1];
    assign rgb2_pwm = pwm_q[2];

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Directed bench for rgb_led_arbiter with PWM_BITS=4, HOLD_COUNT=4: a grant/busy vector
// table plus hand-written sequences for hold, duty boundaries, reset and sustained grant.
module tb_rgb_led_arbiter;

    localparam int unsigned PB = 4;
    localparam int unsigned HC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    req;
    logic [3*PB-1:0] color0, color1, color2;
    logic [2:0]    grant;
    logic          busy, rgb0_pwm, rgb1_pwm, rgb2_pwm;

    rgb_led_arbiter #(.PWM_BITS(PB), .HOLD_COUNT(HC)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .color0   (color0),
        .color1   (color1),
        .color2   (color2),
        .grant    (grant),
        .busy     (busy),
        .rgb0_pwm (rgb0_pwm),
        .rgb1_pwm (rgb1_pwm),
        .rgb2_pwm (rgb2_pwm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] req;
        logic [2:0] grant;
        logic       busy;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;
    int   pcnt  = 0;  // expected pwm_cnt after the latest edge

    task automatic tick();
        @(posedge clk);
        #1;
        pcnt = (pcnt + 1) % 16;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        pcnt = 0;
    endtask

    task automatic count_n(input int n, output int c0, output int c1, output int c2);
        c0 = 0; c1 = 0; c2 = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            c0 += int'(rgb0_pwm);
            c1 += int'(rgb1_pwm);
            c2 += int'(rgb2_pwm);
        end
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < 32 && pcnt != p; i++) tick();
    endtask

    task automatic add(input logic [2:0] r, input logic [2:0] g, input logic b);
        vec_t v;
        v.req = r; v.grant = g; v.busy = b;
        vq.push_back(v);
    endtask

    int c0, c1, c2;

    initial begin
        rst = 1'b1; req = '0; color0 = '0; color1 = '0; color2 = '0;

        // Priority, hold, keep-at-zero, fall-through and all-ones cases.
        add(3'b110, 3'b010, 1); add(3'b111, 3'b010, 1); add(3'b111, 3'b010, 1);
        add(3'b111, 3'b010, 1); add(3'b111, 3'b001, 1); add(3'b000, 3'b001, 1);
        add(3'b000, 3'b001, 1); add(3'b000, 3'b001, 1); add(3'b000, 3'b000, 0);
        add(3'b010, 3'b010, 1); add(3'b110, 3'b010, 1); add(3'b110, 3'b010, 1);
        add(3'b110, 3'b010, 1); add(3'b110, 3'b010, 1); add(3'b110, 3'b010, 1);
        add(3'b100, 3'b100, 1); add(3'b000, 3'b100, 1); add(3'b000, 3'b100, 1);
        add(3'b000, 3'b100, 1); add(3'b000, 3'b000, 0); add(3'b111, 3'b001, 1);
        add(3'b000, 3'b001, 1); add(3'b000, 3'b001, 1); add(3'b000, 3'b001, 1);
        add(3'b000, 3'b000, 0);

        do_reset();
        check("reset_grant", int'(grant), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_rgb", int'({rgb2_pwm, rgb1_pwm, rgb0_pwm}), 0);
        check("reset_pwm_cnt", int'(dut.pwm_cnt_q), 0);

        foreach (vq[i]) begin
            req = vq[i].req;
            tick();
            check($sformatf("vec%0d_grant", i), int'(grant), int'(vq[i].grant));
            check($sformatf("vec%0d_busy", i), int'(busy), int'(vq[i].busy));
        end

        // Hold with dropped request; a wrap lands inside the active window.
        req = '0;
        do_reset();
        color2 = 12'hF80;
        wait_phase(13);
        req = 3'b100;
        tick();
        check("hold_grant_e0", int'(grant), 4);
        req = '0;
        tick(); check("hold_grant_e1", int'(grant), 4);
        tick(); check("hold_grant_e2", int'(grant), 4);
        c0 = 0; c1 = 0; c2 = 0;
        for (int k = 3; k <= 18; k++) begin
            tick();
            c0 += int'(rgb0_pwm); c1 += int'(rgb1_pwm); c2 += int'(rgb2_pwm);
            if (k == 3) check("hold_grant_e3", int'(grant), 4);
            if (k == 4) begin
                check("hold_grant_e4", int'(grant), 0);
                check("hold_busy_e4", int'(busy), 0);
            end
        end
        check("hold_rgb0_cnt", c0, 0);
        check("hold_rgb1_cnt", c1, 8);
        check("hold_rgb2_cnt", c2, 15);
        count_n(16, c0, c1, c2);
        check("idle_rgb_cnt", c0 + c1 + c2, 0);

        // Duty boundaries and a mid-period colour change.
        color2 = '0;
        do_reset();
        req = 3'b001; color0 = 12'h0F0;
        for (int i = 0; i < 40; i++) tick();
        count_n(16, c0, c1, c2);
        check("bound_rgb0_cnt", c0, 0);
        check("bound_rgb1_cnt", c1, 15);
        check("bound_rgb2_cnt", c2, 0);
        wait_phase(5);
        color0 = 12'h0F8;
        count_n(11, c0, c1, c2);
        check("midchg_before_wrap", c0, 0);
        count_n(16, c0, c1, c2);
        check("midchg_after_wrap", c0, 8);
        check("midchg_rgb1", c1, 15);

        // Reset while active with hold_cnt=2.
        do_reset();
        req = 3'b010; color0 = 12'hFFF; color1 = 12'hFFF;
        for (int i = 0; i < 24; i++) tick();
        count_n(16, c0, c1, c2);
        check("pre_rst_rgb0_cnt", c0, 15);
        check("pre_rst_rgb2_cnt", c2, 15);
        req = 3'b011;
        tick();
        check("pre_rst_switch", int'(grant), 1);
        tick();
        check("pre_rst_hold", int'(grant), 1);
        do_reset();
        check("rst_mid_grant", int'(grant), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_rgb", int'({rgb2_pwm, rgb1_pwm, rgb0_pwm}), 0);
        check("rst_mid_pwm_cnt", int'(dut.pwm_cnt_q), 0);
        tick();
        check("post_rst_grant", int'(grant), 1);
        check("post_rst_pwm_cnt", int'(dut.pwm_cnt_q), 1);
        check("post_rst_rgb", int'({rgb2_pwm, rgb1_pwm, rgb0_pwm}), 0);

        // Sustained single grant, then a colour update taking effect at the wrap.
        req = '0; color0 = '0; color1 = 12'h040;
        do_reset();
        req = 3'b010;
        for (int i = 0; i < 40; i++) begin
            tick();
            check($sformatf("sustain_grant%0d", i), int'(grant), 2);
        end
        wait_phase(0);
        check("sustain_pwm_cnt", int'(dut.pwm_cnt_q), 0);
        color1 = 12'h0C0;
        count_n(16, c0, c1, c2);
        check("sustain_old_duty", c1, 4);
        count_n(16, c0, c1, c2);
        check("sustain_new_duty", c1, 12);
        check("sustain_grant_end", int'(grant), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
